layer_sequencer: RTL and testbench

Time-multiplexed controller for one fully connected layer. One shared multiply-accumulate datapath computes every neuron of the layer in turn. For each neuron it walks the input vector and weight memory one element per cycle, adds the bias, saturates to Q1.15, and streams the results out over a valid/ready handshake. It sits between the layer's input buffer and weight/bias memories and the next layer's input buffer.

---
 rtl/nn_pkg.sv | 32 +++
 rtl/mac_unit.sv | 72 +++++++
 rtl/layer_sequencer.sv | 139 +++++++++++++
 tb/tb_layer_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the fully connected layer datapath.
package nn_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned FRAC_BITS = 15;
   // Width of the value handed to sat_q15; callers sign-extend their accumulator up to it.
   localparam int unsigned SAT_IN_W  = 64;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StAccum,
      StDrain,
      StFinal,
      StEmit,
      StDone
   } state_e;

   // Rescale a Q2.30-aligned sum to Q1.15 (floor) and clamp to the 16-bit signed range.
   function automatic logic [DATA_W-1:0] sat_q15(input logic signed [SAT_IN_W-1:0] s);
      logic signed [SAT_IN_W-1:0] q;
      q = s >>> FRAC_BITS;
      if (q > 64'sd32767) begin
         return 16'h7FFF;
      end else if (q < -64'sd32768) begin
         return 16'h8000;
      end else begin
         return DATA_W'(q);
      end
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Shared multiply-accumulate datapath: product, accumulator, bias latch, rescale and saturate.
// Define RELU_EN to clamp negative results to zero (hidden layers).
module mac_unit
   import nn_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = 42
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              acc_en,
   input  logic              bias_en,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] w_data,
   input  logic [DATA_W-1:0] b_data,
   output logic [DATA_W-1:0] result
);

   logic signed [2*DATA_W-1:0]  prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] bias_ext;
   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]           bias_q, bias_d;
   logic [DATA_W-1:0]           result_q, result_d;
   logic [DATA_W-1:0]           sat;

   always_comb begin
      prod     = $signed(in_data) * $signed(w_data);
      prod_ext = {{(ACC_WIDTH-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      bias_ext = {{(ACC_WIDTH-DATA_W){bias_q[DATA_W-1]}}, bias_q};
      sum      = acc_q + (bias_ext <<< FRAC_BITS);
      sat      = sat_q15({{(SAT_IN_W-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum});
`ifdef RELU_EN
      if (sat[DATA_W-1]) begin
         sat = '0;
      end
`endif

      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (acc_en) begin
         acc_d = acc_q + prod_ext;
      end

      bias_d = bias_q;
      if (clear) begin
         bias_d = '0;
      end else if (bias_en) begin
         bias_d = b_data;
      end

      result_d = load ? sat : result_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         bias_q   <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         bias_q   <= bias_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: rtl/layer_sequencer.sv
// Time-multiplexed controller for one fully connected layer: FSM, counters, address
// generation and output handshake around a shared mac_unit (RELU_EN selects ReLU output).
module layer_sequencer
   import nn_pkg::*;
#(
   parameter int unsigned INPUT_SIZE  = 784,
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned ACC_WIDTH   = 42,
   localparam int unsigned NW         = $clog2(NUM_NEURONS),
   localparam int unsigned WAW        = $clog2(INPUT_SIZE * NUM_NEURONS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_W-1:0]     in_data,
   output logic [WAW-1:0]        w_addr,
   input  logic [DATA_W-1:0]     w_data,
   output logic [NW-1:0]         b_addr,
   input  logic [DATA_W-1:0]     b_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [NW-1:0]         out_idx
);

   state_e                state_q, state_d;
   logic [NW-1:0]         n_q, n_d;
   logic [ADDR_WIDTH-1:0] k_q, k_d;
   logic [NW-1:0]         out_idx_q, out_idx_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  mac_clear;
   logic                  acc_en;
   logic                  bias_en;
   logic                  load;

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      k_d       = k_q;
      out_idx_d = out_idx_q;
      mac_clear = 1'b0;
      bias_en   = 1'b0;
      load      = 1'b0;
      // Memory data lags the address by one cycle, so accumulate one cycle behind ACCUM.
      rd_vld_d  = (state_q == StAccum);
      acc_en    = rd_vld_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StClear;
               n_d     = '0;
            end
         end
         StClear: begin
            mac_clear = 1'b1;
            k_d       = '0;
            state_d   = StAccum;
         end
         StAccum: begin
            bias_en = (k_q == '0);
            // k parks on the last index so addresses stay put through DRAIN..EMIT.
            if (k_q == ADDR_WIDTH'(INPUT_SIZE - 1)) begin
               state_d = StDrain;
            end else begin
               k_d = k_q + ADDR_WIDTH'(1);
            end
         end
         StDrain: begin
            state_d = StFinal;
         end
         StFinal: begin
            load      = 1'b1;
            out_idx_d = n_q;
            state_d   = StEmit;
         end
         StEmit: begin
            if (out_ready) begin
               if (n_q == NW'(NUM_NEURONS - 1)) begin
                  state_d = StDone;
               end else begin
                  n_d     = n_q + NW'(1);
                  state_d = StClear;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         n_q       <= '0;
         k_q       <= '0;
         out_idx_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         k_q       <= k_d;
         out_idx_q <= out_idx_d;
         rd_vld_q  <= rd_vld_d;
      end
   end

   mac_unit #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clear   (mac_clear),
      .acc_en  (acc_en),
      .bias_en (bias_en),
      .load    (load),
      .in_data (in_data),
      .w_data  (w_data),
      .b_data  (b_data),
      .result  (out_data)
   );

   assign in_addr   = k_q;
   assign w_addr    = WAW'(n_q) * WAW'(INPUT_SIZE) + WAW'(k_q);
   assign b_addr    = n_q;
   assign out_idx   = out_idx_q;
   assign busy      = (state_q != StIdle) && (state_q != StDone);
   assign done      = (state_q == StDone);
   assign out_valid = (state_q == StEmit);

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer (INPUT_SIZE=4, NUM_NEURONS=2); expectations follow
// RELU_EN when it is defined.
module tb_layer_sequencer;

   localparam int I    = 4;
   localparam int N    = 2;
   localparam int AW   = 2;
   localparam int ACCW = 42;
   localparam int NW   = 1;
   localparam int WAW  = 3;

   logic           clk = 1'b0;
   logic           rst, start, out_ready;
   logic           busy, done, out_valid;
   logic [AW-1:0]  in_addr;
   logic [WAW-1:0] w_addr;
   logic [NW-1:0]  b_addr, out_idx;
   logic [15:0]    in_data, w_data, b_data, out_data;

   logic [15:0] in_mem [I];
   logic [15:0] w_mem  [I*N];
   logic [15:0] b_mem  [N];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] res_q [$];
   int          idx_q [$];
   int          done_cnt, first_valid, done_at, last_xfer;

   typedef struct {
      logic [15:0] iv, wv, bv, exp_lin, exp_relu;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   // Synchronous memories with one cycle of read latency.
   always @(posedge clk) begin
      in_data <= in_mem[in_addr];
      w_data  <= w_mem[w_addr];
      b_data  <= b_mem[b_addr];
   end

   layer_sequencer #(
      .INPUT_SIZE  (I),
      .NUM_NEURONS (N),
      .ADDR_WIDTH  (AW),
      .ACC_WIDTH   (ACCW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Dot product plus bias in plain integer arithmetic, floored to Q1.15 then clamped.
   function automatic logic [15:0] model(input int n);
      longint s, q;
      s = 0;
      for (int k = 0; k < I; k++) begin
         s += longint'($signed(in_mem[k])) * longint'($signed(w_mem[n*I+k]));
      end
      s += longint'($signed(b_mem[n])) * 32768;
      q = s >>> 15;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
`ifdef RELU_EN
      if (q < 0) q = 0;
`endif
      return 16'(q);
   endfunction

   function automatic logic [15:0] pick(input vec_t v);
`ifdef RELU_EN
      return v.exp_relu;
`else
      return v.exp_lin;
`endif
   endfunction

   task automatic fill(input logic [15:0] iv, input logic [15:0] wv, input logic [15:0] bv);
      for (int k = 0; k < I; k++) in_mem[k] = iv;
      for (int k = 0; k < I*N; k++) w_mem[k] = wv;
      for (int k = 0; k < N; k++) b_mem[k] = bv;
   endtask

   task automatic fill_random();
      for (int k = 0; k < I; k++) in_mem[k] = 16'($urandom);
      for (int k = 0; k < I*N; k++) w_mem[k] = 16'($urandom);
      for (int k = 0; k < N; k++) b_mem[k] = 16'($urandom);
   endtask

   // One layer pass; cyc counts cycles after the edge that accepts start (CLEAR is cyc 0).
   task automatic run_pass(input int stall, input bit rand_ready, input bit poke);
      int             cyc, stall_left;
      logic [15:0]    hd;
      logic [NW-1:0]  hi;
      logic [AW-1:0]  ha;
      logic [WAW-1:0] hw;
      res_q.delete();
      idx_q.delete();
      done_cnt = 0; first_valid = -1; done_at = -1; last_xfer = -1;
      stall_left = stall;
      hd = '0; hi = '0; ha = '0; hw = '0;
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      check("busy_after_start", busy, 1);
      while (cyc < 400) begin
         if (poke) start = (cyc >= 3 && cyc < 12);
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
            check("busy_low_in_done", busy, 0);
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && stall_left > 0) begin
            if (stall_left == stall) begin
               hd = out_data; hi = out_idx; ha = in_addr; hw = w_addr;
            end else begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, hd);
               check("stall_idx", out_idx, hi);
               check("stall_in_addr", in_addr, ha);
               check("stall_w_addr", w_addr, hw);
            end
            stall_left--;
            out_ready = 1'b0;
         end else if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            res_q.push_back(out_data);
            idx_q.push_back(int'(out_idx));
            last_xfer = cyc;
         end
         if (done_at >= 0 && cyc >= done_at + 3) break;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      check("pass_completed", longint'(done_at >= 0), 1);
      check("result_count", res_q.size(), N);
      check("done_pulses", done_cnt, 1);
      check("done_after_last_xfer", done_at, last_xfer + 1);
   endtask

   task automatic check_results(input string tag, input logic [15:0] exp0,
                                input logic [15:0] exp1);
      if (res_q.size() == N) begin
         check({tag, "_idx0"}, idx_q[0], 0);
         check({tag, "_idx1"}, idx_q[1], 1);
         check({tag, "_data0"}, res_q[0], exp0);
         check({tag, "_data1"}, res_q[1], exp1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{16'h2000, 16'h2000, 16'h0100, 16'h2100, 16'h2100};
      tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
      tbl[2] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h0000};
      tbl[3] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
      tbl[4] = '{16'h1000, 16'hF000, 16'h0400, 16'hFC00, 16'h0000};
      tbl[5] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};

      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      fill(16'h0, 16'h0, 16'h0);
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_addr", in_addr, 0);
      check("rst_w_addr", w_addr, 0);
      check("rst_b_addr", b_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 6; t++) begin
         fill(tbl[t].iv, tbl[t].wv, tbl[t].bv);
         run_pass(0, 1'b0, 1'b0);
         check($sformatf("tbl%0d_first_valid", t), first_valid, I + 3);
         check($sformatf("tbl%0d_done_at", t), done_at, N * (I + 4));
         check_results($sformatf("tbl%0d", t), pick(tbl[t]), pick(tbl[t]));
      end

      // Consumer stalls the first result for 5 cycles.
      fill(16'h2000, 16'h2000, 16'h0100);
      run_pass(5, 1'b0, 1'b0);
      check_results("stall", 16'h2100, 16'h2100);

      // Reset in the middle of neuron 0's accumulation.
      fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_addr", in_addr, 0);
      check("mid_rst_w_addr", w_addr, 0);
      check("mid_rst_b_addr", b_addr, 0);
      check("mid_rst_out_data", out_data, 0);
      repeat (3) @(negedge clk);
      check("mid_rst_idle_busy", busy, 0);
      check("mid_rst_idle_valid", out_valid, 0);
      fill(16'h2000, 16'h2000, 16'h0100);
      run_pass(0, 1'b0, 1'b0);
      check_results("after_rst", 16'h2100, 16'h2100);

      // start held high while busy must not launch or queue another pass.
      fill(16'h0001, 16'hFFFF, 16'h0000);
      run_pass(0, 1'b0, 1'b1);
      check_results("poke", pick(tbl[3]), pick(tbl[3]));
      repeat (4) @(negedge clk);
      check("poke_idle_busy", busy, 0);

      // Random data with a randomly ready consumer, against the reference model.
      for (int r = 0; r < 8; r++) begin
         fill_random();
         run_pass(0, 1'b1, 1'b0);
         check_results($sformatf("rand%0d", r), model(0), model(1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
